// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame buffer: default geometry,
// controller state type and the pixel-to-tile address mapping.
package fb_pkg;

    localparam int         FB_H_RES        = 320;
    localparam int         FB_V_RES        = 240;
    localparam int         FB_PIXEL_W      = 8;
    localparam int         FB_COORD_W      = 9;
    localparam int         FB_BANKS_X      = 2;
    localparam int         FB_BANKS_Y      = 2;
    localparam logic [7:0] FB_BORDER_COLOR = 8'hFF;

    typedef enum logic [0:0] {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_e;

    // Tile column, tile row and address inside that tile for one pixel.
    typedef struct packed {
        logic [31:0] bx;
        logic [31:0] by;
        logic [31:0] addr;
    } fb_loc_t;

    // Maps (x, y) onto the tile grid. The arithmetic is carried at 32 bits so
    // the row*width product can never wrap; callers truncate the local address
    // to the RAM address width, which always holds a value below TW*TH.
    function automatic fb_loc_t fb_tile_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] tw,
                                             input logic [31:0] th);
        fb_loc_t loc;
        loc.bx   = x / tw;
        loc.by   = y / th;
        loc.addr = (y % th) * tw + (x % tw);
        return loc;
    endfunction

endpackage

// File: rtl/fb_tile_ram.sv
// One tile of one page: simple dual-port RAM with a single write port and a
// registered read port, both on the same clock.
module fb_tile_ram #(
    parameter int DEPTH   = 19200,
    parameter int PIXEL_W = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    // Write on enable, read every cycle; a same-address read returns old data.
    // NOTE: the storage array has no reset so it maps onto block RAM; only
    // control state around it is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_buffer_pp.sv
// Double-buffered, tiled frame buffer. Draw engines write the back page,
// scan-out reads the front page, page swaps happen only on vertical blank,
// and a clear engine can flood-fill the back page one tile address per cycle.
module frame_buffer_pp
    import fb_pkg::*;
#(
    parameter int                 H_RES        = FB_H_RES,
    parameter int                 V_RES        = FB_V_RES,
    parameter int                 PIXEL_W      = FB_PIXEL_W,
    parameter int                 COORD_W      = FB_COORD_W,
    parameter int                 BANKS_X      = FB_BANKS_X,
    parameter int                 BANKS_Y      = FB_BANKS_Y,
    parameter logic [PIXEL_W-1:0] BORDER_COLOR = FB_BORDER_COLOR
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               WR_VALID,
    output logic               WR_READY,
    input  logic [COORD_W-1:0] WR_X,
    input  logic [COORD_W-1:0] WR_Y,
    input  logic [PIXEL_W-1:0] WR_PIXEL,
    input  logic               RD_EN,
    input  logic [COORD_W-1:0] RD_X,
    input  logic [COORD_W-1:0] RD_Y,
    output logic               RD_VALID,
    output logic [PIXEL_W-1:0] RD_PIXEL,
    input  logic               SWAP_REQ,
    input  logic               VBLANK_STROBE,
    output logic               SWAP_DONE,
    output logic               FRONT_PAGE,
    input  logic               CLEAR_REQ,
    input  logic [PIXEL_W-1:0] CLEAR_COLOR,
    output logic               CLEAR_BUSY
);

    localparam int TW    = H_RES / BANKS_X;
    localparam int TH    = V_RES / BANKS_Y;
    localparam int DEPTH = TW * TH;
    localparam int AW    = $clog2(DEPTH);
    localparam int NT    = BANKS_X * BANKS_Y;
    localparam int TIW   = (NT > 1) ? $clog2(NT) : 1;

    // Controller state
    fb_state_e          state;
    logic [AW-1:0]      clr_cnt;
    logic [PIXEL_W-1:0] clr_color;
    logic               front;
    logic               pending;
    logic               swap_done_q;
    logic               ready_q;

    // Write-side decode
    fb_loc_t            wr_loc;
    logic               wr_in_range;
    logic [TIW-1:0]     wr_tile;
    logic [AW-1:0]      wr_addr;
    logic               wr_do;
    logic               clr_we;
    logic               swap_exec;
    logic [AW-1:0]      ram_wa;
    logic [PIXEL_W-1:0] ram_wd;

    // Read-side decode and pipeline
    fb_loc_t            rd_loc;
    logic               rd_in_range;
    logic               rd_v1, rd_v2;
    logic [AW-1:0]      rd_addr1;
    logic [TIW-1:0]     rd_tile1, rd_tile2;
    logic               rd_oor1, rd_oor2;
    logic               rd_page1, rd_page2;
    logic [PIXEL_W-1:0] ram_q [2][NT];

    // Ready is forced low for as long as reset is held.
    assign WR_READY   = ready_q && !RESET;
    assign CLEAR_BUSY = (state == FB_CLEAR);
    assign FRONT_PAGE = front;
    assign SWAP_DONE  = swap_done_q;
    assign RD_VALID   = rd_v2;

    // Pixel-to-tile decode for both ports; out-of-range coordinates are flagged.
    // NOTE: every always_comb output gets a default first so no latch can form.
    always_comb begin
        wr_loc      = fb_tile_addr(32'(WR_X), 32'(WR_Y), TW, TH);
        rd_loc      = fb_tile_addr(32'(RD_X), 32'(RD_Y), TW, TH);
        wr_in_range = (32'(WR_X) < H_RES) && (32'(WR_Y) < V_RES);
        rd_in_range = (32'(RD_X) < H_RES) && (32'(RD_Y) < V_RES);
        wr_tile     = TIW'(wr_loc.by * BANKS_X + wr_loc.bx);
        wr_addr     = AW'(wr_loc.addr);
    end

    // Accepted out-of-range writes are consumed without touching any RAM.
    assign wr_do     = WR_VALID && WR_READY && wr_in_range;
    assign clr_we    = (state == FB_CLEAR) && !RESET;
    assign swap_exec = VBLANK_STROBE && (pending || SWAP_REQ) && (state == FB_IDLE);

    // Shared back-page write port: the clear engine owns it while clearing.
    always_comb begin
        ram_wa = wr_addr;
        ram_wd = WR_PIXEL;
        if (clr_we) begin
            ram_wa = clr_cnt;
            ram_wd = clr_color;
        end
    end

    // Clear FSM, page-swap bookkeeping and write-ready.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= FB_IDLE;
            clr_cnt     <= '0;
            clr_color   <= '0;
            front       <= 1'b0;
            pending     <= 1'b0;
            swap_done_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            swap_done_q <= swap_exec;
            if (swap_exec) begin
                front <= ~front;
            end
            if (swap_exec) begin
                pending <= 1'b0;
            end else if (SWAP_REQ) begin
                pending <= 1'b1;
            end
            case (state)
                FB_IDLE: begin
                    ready_q <= !CLEAR_REQ;
                    if (CLEAR_REQ) begin
                        state     <= FB_CLEAR;
                        clr_cnt   <= '0;
                        clr_color <= CLEAR_COLOR;
                    end
                end
                FB_CLEAR: begin
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state   <= FB_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= FB_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Read stage 1: register address, tile, page and border flag.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_v1    <= 1'b0;
            rd_addr1 <= '0;
            rd_tile1 <= '0;
            rd_oor1  <= 1'b0;
            rd_page1 <= 1'b0;
        end else begin
            rd_v1    <= RD_EN;
            rd_addr1 <= AW'(rd_loc.addr);
            rd_tile1 <= TIW'(rd_loc.by * BANKS_X + rd_loc.bx);
            rd_oor1  <= !rd_in_range;
            rd_page1 <= front;
        end
    end

    // Read stage 2: carry the mux selects alongside the RAM output register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_v2    <= 1'b0;
            rd_tile2 <= '0;
            rd_oor2  <= 1'b0;
            rd_page2 <= 1'b0;
        end else begin
            rd_v2    <= rd_v1;
            rd_tile2 <= rd_tile1;
            rd_oor2  <= rd_oor1;
            rd_page2 <= rd_page1;
        end
    end

    // Output mux: border colour for off-screen reads, zero when idle.
    always_comb begin
        RD_PIXEL = '0;
        if (rd_v2) begin
            RD_PIXEL = rd_oor2 ? BORDER_COLOR : ram_q[rd_page2][rd_tile2];
        end
    end

    // Two pages of BANKS_X*BANKS_Y tiles; only back-page tiles are writable.
    for (genvar p = 0; p < 2; p++) begin : g_page
        for (genvar t = 0; t < NT; t++) begin : g_tile
            localparam logic PAGE = (p != 0);
            logic we;

            assign we = (PAGE != front) &&
                        (clr_we || (wr_do && (wr_tile == TIW'(t))));

            fb_tile_ram #(
                .DEPTH  (DEPTH),
                .PIXEL_W(PIXEL_W),
                .AW     (AW)
            ) u_ram (
                .clk    (CLOCK_50),
                .wr_en  (we),
                .wr_addr(ram_wa),
                .wr_data(ram_wd),
                .rd_addr(rd_addr1),
                .rd_data(ram_q[p][t])
            );
        end
    end

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Self-checking bench for frame_buffer_pp. A flat (x, y) frame model per page
// predicts every output each cycle; directed sections pin the model with
// hand-computed values, and a randomized section exercises everything at once.
module tb_frame_buffer_pp;

    localparam int H     = 320;
    localparam int V     = 240;
    localparam int TW    = 160;
    localparam int TH    = 120;
    localparam int DEPTH = TW * TH;
    localparam int N     = H * V;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       WR_VALID, WR_READY;
    logic [8:0] WR_X, WR_Y;
    logic [7:0] WR_PIXEL;
    logic       RD_EN, RD_VALID;
    logic [8:0] RD_X, RD_Y;
    logic [7:0] RD_PIXEL;
    logic       SWAP_REQ, VBLANK_STROBE, SWAP_DONE, FRONT_PAGE;
    logic       CLEAR_REQ, CLEAR_BUSY;
    logic [7:0] CLEAR_COLOR;

    always #5 CLOCK_50 = ~CLOCK_50;

    frame_buffer_pp #(
        .H_RES(H), .V_RES(V), .PIXEL_W(8), .COORD_W(9),
        .BANKS_X(2), .BANKS_Y(2), .BORDER_COLOR(8'hFF)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_X(WR_X), .WR_Y(WR_Y), .WR_PIXEL(WR_PIXEL),
        .RD_EN(RD_EN), .RD_X(RD_X), .RD_Y(RD_Y),
        .RD_VALID(RD_VALID), .RD_PIXEL(RD_PIXEL),
        .SWAP_REQ(SWAP_REQ), .VBLANK_STROBE(VBLANK_STROBE),
        .SWAP_DONE(SWAP_DONE), .FRONT_PAGE(FRONT_PAGE),
        .CLEAR_REQ(CLEAR_REQ), .CLEAR_COLOR(CLEAR_COLOR),
        .CLEAR_BUSY(CLEAR_BUSY)
    );

    // Reference model: whole frame per page, indexed by y*H + x.
    logic [7:0] mem   [2][N];
    bit         known [2][N];
    bit         m_front, m_pending, m_clear, m_ready, m_done;
    int         m_cnt;
    logic [7:0] m_color;

    typedef struct {
        bit         valid;
        bit         known;
        logic [7:0] pix;
    } rd_t;
    rd_t e1, e2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit  exec;
        bit  old_front;
        rd_t nr;
        int  x, y;
        if (RESET) begin
            m_front = 0; m_pending = 0; m_clear = 0; m_ready = 0; m_done = 0;
            e1.valid = 0; e1.known = 0; e1.pix = 8'h00;
            e2 = e1;
            return;
        end
        old_front = m_front;
        e2 = e1;
        nr.valid = RD_EN;
        nr.known = 1;
        nr.pix   = 8'hFF;
        if (RD_EN && int'(RD_X) < H && int'(RD_Y) < V) begin
            nr.known = known[old_front][int'(RD_Y) * H + int'(RD_X)];
            nr.pix   = mem[old_front][int'(RD_Y) * H + int'(RD_X)];
        end
        e1 = nr;

        exec   = VBLANK_STROBE && (m_pending || SWAP_REQ) && !m_clear;
        m_done = exec;
        if (exec) m_front = !m_front;
        if (exec) m_pending = 0;
        else if (SWAP_REQ) m_pending = 1;

        if (WR_VALID && m_ready && int'(WR_X) < H && int'(WR_Y) < V) begin
            mem[!old_front][int'(WR_Y) * H + int'(WR_X)]   = WR_PIXEL;
            known[!old_front][int'(WR_Y) * H + int'(WR_X)] = 1;
        end

        if (m_clear) begin
            for (int by = 0; by < 2; by++) begin
                for (int bx = 0; bx < 2; bx++) begin
                    x = bx * TW + m_cnt % TW;
                    y = by * TH + m_cnt / TW;
                    mem[!old_front][y * H + x]   = m_color;
                    known[!old_front][y * H + x] = 1;
                end
            end
            if (m_cnt == DEPTH - 1) m_clear = 0;
            else m_cnt++;
        end else if (CLEAR_REQ) begin
            m_clear = 1;
            m_cnt   = 0;
            m_color = CLEAR_COLOR;
        end
        m_ready = !m_clear;
    endtask

    task automatic compare();
        check("wr_ready",   WR_READY,   m_ready && !RESET);
        check("clear_busy", CLEAR_BUSY, m_clear);
        check("front_page", FRONT_PAGE, m_front);
        check("swap_done",  SWAP_DONE,  m_done);
        check("rd_valid",   RD_VALID,   e2.valid);
        if (e2.valid && e2.known) check("rd_pixel", RD_PIXEL, e2.pix);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        compare();
    endtask

    task automatic write_px(input int x, input int y, input logic [7:0] p);
        int g = 0;
        while (!WR_READY && g < 30000) begin
            tick();
            g++;
        end
        check("write_ready_wait", WR_READY, 1);
        WR_VALID = 1; WR_X = 9'(x); WR_Y = 9'(y); WR_PIXEL = p;
        tick();
        WR_VALID = 0;
    endtask

    task automatic read_px(input int x, input int y, output logic [7:0] pix);
        RD_EN = 1; RD_X = 9'(x); RD_Y = 9'(y);
        tick();
        RD_EN = 0;
        check("rd_valid_at_t1", RD_VALID, 0);
        tick();
        check("rd_valid_at_t2", RD_VALID, 1);
        pix = RD_PIXEL;
    endtask

    task automatic swap_same_cycle();
        SWAP_REQ = 1; VBLANK_STROBE = 1;
        tick();
        SWAP_REQ = 0; VBLANK_STROBE = 0;
        check("swap_done_pulse", SWAP_DONE, 1);
        tick();
        check("swap_done_drop", SWAP_DONE, 0);
    endtask

    initial begin
        logic [7:0] px;
        int         low, guard;

        RESET = 1; WR_VALID = 0; WR_X = 0; WR_Y = 0; WR_PIXEL = 0;
        RD_EN = 0; RD_X = 0; RD_Y = 0; SWAP_REQ = 0; VBLANK_STROBE = 0;
        CLEAR_REQ = 0; CLEAR_COLOR = 0;
        repeat (3) tick();
        check("reset_wr_ready", WR_READY, 0);
        check("reset_rd_pixel", RD_PIXEL, 0);
        check("reset_front",    FRONT_PAGE, 0);
        RESET = 0;
        tick();
        check("ready_after_reset", WR_READY, 1);

        // Single pixel through a separate request/strobe swap.
        write_px(5, 7, 8'h3C);
        SWAP_REQ = 1; tick(); SWAP_REQ = 0;
        VBLANK_STROBE = 1; tick(); VBLANK_STROBE = 0;
        check("first_swap_done", SWAP_DONE, 1);
        check("first_swap_front", FRONT_PAGE, 1);
        tick();
        read_px(5, 7, px);
        check("pixel_5_7", px, 8'h3C);

        // Tile corners, including two pixels sharing local address 0.
        write_px(0, 0, 8'hA1);
        write_px(159, 119, 8'hB2);
        write_px(160, 0, 8'hC3);
        write_px(319, 239, 8'hD4);
        swap_same_cycle();
        check("corner_front", FRONT_PAGE, 0);
        read_px(0, 0, px);     check("corner_0_0", px, 8'hA1);
        read_px(159, 119, px); check("corner_159_119", px, 8'hB2);
        read_px(160, 0, px);   check("corner_160_0", px, 8'hC3);
        read_px(319, 239, px); check("corner_319_239", px, 8'hD4);

        // Out-of-range writes must not land on any aliased pixel.
        write_px(0, 0, 8'h55);
        write_px(0, 120, 8'h66);
        write_px(320, 0, 8'hAA);
        write_px(0, 240, 8'hBB);
        swap_same_cycle();
        read_px(0, 0, px);    check("oor_keep_0_0", px, 8'h55);
        read_px(0, 120, px);  check("oor_keep_0_120", px, 8'h66);
        read_px(5, 7, px);    check("oor_keep_5_7", px, 8'h3C);
        read_px(400, 10, px); check("border_400_10", px, 8'hFF);

        // Randomized traffic on every input except clear.
        for (int i = 0; i < 600; i++) begin
            WR_VALID      = 1'($urandom_range(0, 1));
            WR_X          = 9'($urandom_range(0, 330));
            WR_Y          = 9'($urandom_range(0, 250));
            WR_PIXEL      = 8'($urandom);
            RD_EN         = 1'($urandom_range(0, 1));
            RD_X          = 9'($urandom_range(0, 330));
            RD_Y          = 9'($urandom_range(0, 250));
            SWAP_REQ      = ($urandom_range(0, 19) == 0);
            VBLANK_STROBE = ($urandom_range(0, 14) == 0);
            tick();
        end
        WR_VALID = 0; RD_EN = 0; SWAP_REQ = 0;
        VBLANK_STROBE = 1; tick(); VBLANK_STROBE = 0;
        repeat (2) tick();

        // Full clear with a swap requested and strobed mid-clear.
        CLEAR_COLOR = 8'h12; CLEAR_REQ = 1;
        tick();
        CLEAR_REQ = 0; CLEAR_COLOR = 8'h00;
        low = 0; guard = 0;
        while (CLEAR_BUSY && guard < 25000) begin
            if (!WR_READY) low++;
            SWAP_REQ      = (guard == 100);
            VBLANK_STROBE = (guard == 200);
            CLEAR_REQ     = (guard == 300);
            tick();
            if (guard == 200) check("no_swap_in_clear", SWAP_DONE, 0);
            guard++;
        end
        SWAP_REQ = 0; VBLANK_STROBE = 0; CLEAR_REQ = 0;
        check("clear_ready_low_cycles", low, 19200);
        check("clear_busy_fell", CLEAR_BUSY, 0);
        check("ready_after_clear", WR_READY, 1);
        VBLANK_STROBE = 1; tick(); VBLANK_STROBE = 0;
        check("deferred_swap_done", SWAP_DONE, 1);
        for (int y = 0; y < V; y++) begin
            if (y % 8 == 0 || y == 119 || y == 120 || y == 239) begin
                for (int x = 0; x < H; x++) begin
                    RD_EN = 1; RD_X = 9'(x); RD_Y = 9'(y);
                    tick();
                end
            end
        end
        RD_EN = 0;
        repeat (2) tick();
        read_px(0, 0, px);     check("clear_0_0", px, 8'h12);
        read_px(160, 120, px); check("clear_160_120", px, 8'h12);
        read_px(319, 239, px); check("clear_319_239", px, 8'h12);

        // Reset 100 cycles into a clear with a swap pending.
        CLEAR_COLOR = 8'h77; CLEAR_REQ = 1;
        tick();
        CLEAR_REQ = 0;
        for (int i = 0; i < 100; i++) begin
            SWAP_REQ = (i == 10);
            tick();
        end
        SWAP_REQ = 0;
        RESET = 1;
        tick();
        check("rst_clear_busy", CLEAR_BUSY, 0);
        check("rst_front", FRONT_PAGE, 0);
        check("rst_ready_held", WR_READY, 0);
        RESET = 0;
        tick();
        check("rst_ready_after", WR_READY, 1);
        VBLANK_STROBE = 1; tick(); VBLANK_STROBE = 0;
        check("rst_pending_cleared", SWAP_DONE, 0);
        check("rst_front_kept", FRONT_PAGE, 0);
        for (int i = 0; i < 40; i++) begin
            RD_EN = 1; RD_X = 9'($urandom_range(0, 330)); RD_Y = 9'($urandom_range(0, 250));
            tick();
        end
        RD_EN = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
